multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the register-file/ALU datapath. Replaces the
//  free-running PC with an FSM: fetch from the synchronous inst_mem,
//  latch IR, decode R-type func to ALU_OP, let the ALU settle, then pulse
//  the register-file write enable once.
//  Adds run / single-step / halt control and a retired-instruction count
//  for board debug.
// PARAMETERS
//  ADDR_W  6   inst_mem word-address width; inst_addr = pc[ADDR_W+1:2]
//  CNT_W   16  width of the retired-instruction counter
// PORTS
//  CLK        in   1       clock; all state changes on posedge
//  RST        in   1       asynchronous, active-low reset
//  run        in   1       1 = free-run instructions back to back
//  step_req   in   1       single-step request; its rising edge starts one instruction
//  step_ack   out  1       one-cycle pulse in WB of a stepped instruction
//  inst_addr  out  ADDR_W  word address to inst_mem, = pc[ADDR_W+1:2]
//  inst_code  in   32      inst_mem data; valid 1 cycle after inst_addr
//  ir         out  32      latched instruction (drives rs/rt/rd fields)
//  alu_op     out  3       registered ALU operation
//  reg_we     out  1       register-file write enable; high only in WB
//  pc         out  32      program counter
//  state      out  3       FSM state (debug)
//  halted     out  1       1 once a HALT instruction has decoded
//  retired    out  CNT_W   count of instructions completed in WB
// BEHAVIOUR
//  Reset (RST=0, asynchronous) forces the following, all taking effect
//  immediately, including mid-instruction:
//   - state=IDLE, pc=0, ir=0, alu_op=0
//   - reg_we=0, step_ack=0, halted=0, retired=0, step_req_q=0
//  States: IDLE=0 FETCH=1 WAITF=2 DECODE=3 EXEC=4 WB=5 HALT=6.
//  IDLE:
//   - run=1 -> FETCH.
//   - Else step_req & ~step_req_q (rising edge) -> FETCH, set stepping=1.
//   - Else stay.
//  FETCH  -> WAITF. inst_addr is presented from pc (always driven).
//  WAITF  -> DECODE. On this edge ir <= inst_code.
//  DECODE:
//   - ir==32'hFFFF_FFFF -> HALT.
//   - Else -> EXEC. On this edge alu_op and the valid flag are registered.
//   - Decode, for op=ir[31:26]==0, keyed on func=ir[5:0]:
//     100100 AND=000, 100101 OR=001, 100110 XOR=010, 100111 NOR=011,
//     100000 ADD=100, 100010 SUB=101, 101011 SLTU=110, 000100 SLLV=111.
//   - valid = (op==0) & (func in table) & (rd=ir[15:11] != 0).
//   - Unknown op/func: alu_op=000, valid=0 (executes as NOP).
//  EXEC   -> WB. One full cycle for the ALU to settle; no outputs change.
//  WB (every instruction spends exactly one cycle here):
//   - reg_we = valid, for this one cycle only.
//   - pc <= pc+4; wraps mod 2^(ADDR_W+2), i.e. the last word wraps to 0.
//   - retired <= retired+1; wraps mod 2^CNT_W.
//   - step_ack = stepping; stepping is cleared on exit.
//   - Next state: run=1 -> FETCH, else -> IDLE.
//  HALT:
//   - Absorbing until reset; halted=1; reg_we=0.
//   - pc and retired frozen; HALT does not count as retired.
//  Timing: 5 cycles per instruction; in free-run, back-to-back WB pulses are
//  5 cycles apart.
//  run deasserted mid-instruction: the instruction completes through WB,
//  then IDLE.
//  run and a step edge together in IDLE: run wins, stepping stays 0.
//  Step edges outside IDLE are ignored, not queued; step_req_q samples
//  every cycle.
//  reg_we never asserts outside WB, so writes happen only on decoded
//  R-type instructions.
// TESTING
//  1. Reset release, run=1, ROM[0]=ADD r3,r1,r2 -> WB at cycle 5:
//     reg_we=1, alu_op=100; pc=4, retired=1.
//  2. Free-run of 4 R-type instructions -> reg_we pulses at cycles
//     5, 10, 15, 20; retired=4; pc=16.
//  3. run=0, step_req 0->1 held high -> exactly one instruction,
//     step_ack=1 for 1 cycle, then IDLE.
//     Toggle step_req low then high -> next instruction executes.
//  4. ROM word = 32'hFFFF_FFFF -> HALT after DECODE; halted=1.
//     Further run/step has no effect; pc and retired frozen.
//     RST=0 recovers to IDLE, pc=0.
//  5. Unknown func (6'b001000), and ADD with rd=0 -> both take 5 cycles,
//     reg_we stays 0, retired increments.
//     Fill all 64 words -> pc wraps 252 -> 0.
//  6. RST asserted during EXEC with valid=1 -> reg_we never pulses;
//     state=IDLE, pc=0 immediately; no write occurs.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
//   Instruction-memory bus between the multi-cycle sequencer and a
//   synchronous inst_mem.
//
//   inst_addr : word address presented by the sequencer (always driven)
//   inst_code : instruction word returned by inst_mem one cycle after the
//               address it was read from
//
//   master : sequencer side (drives inst_addr, receives inst_code)
//   slave  : memory side    (receives inst_addr, drives inst_code)
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] inst_addr;
    logic [31:0]       inst_code;

    modport master (
        output inst_addr,
        input  inst_code
    );

    modport slave (
        input  inst_addr,
        output inst_code
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle sequencer for the register-file/ALU datapath. Each instruction
//   walks FETCH -> WAITF -> DECODE -> EXEC -> WB (5 cycles). The R-type func
//   field is decoded into a registered ALU operation, and the register-file
//   write enable is pulsed for the single WB cycle. Run / single-step / halt
//   control and a retired-instruction counter support board debug.
//
// Ports
//   CLK       in   clock, all state changes on posedge
//   RST       in   asynchronous active-low reset
//   run       in   1 = free-run instructions back to back
//   step_req  in   single-step request (rising edge starts one instruction)
//   step_ack  out  one-cycle pulse in WB of a stepped instruction
//   imem      if   inst_mem bus (master): inst_addr = pc[ADDR_W+1:2],
//                  inst_code valid one cycle after inst_addr
//   ir        out  latched instruction word
//   alu_op    out  registered ALU operation
//   reg_we    out  register-file write enable, high only in WB
//   pc        out  program counter (byte address)
//   state     out  FSM state for debug
//   halted    out  1 once a HALT word (32'hFFFF_FFFF) has decoded
//   retired   out  count of instructions completed in WB
//
// Step handshake: step_req is a level; only its 0->1 transition while the
// sequencer sits in IDLE starts an instruction. Edges seen in any other state
// are dropped, not queued. step_ack answers that request with exactly one
// pulse, in the WB cycle of the instruction it started.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              run,
    input  logic              step_req,
    output logic              step_ack,
    multicycle_ctrl_if.master imem,
    output logic [31:0]       ir,
    output logic [2:0]        alu_op,
    output logic              reg_we,
    output logic [31:0]       pc,
    output logic [2:0]        state,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    localparam int PC_W = ADDR_W + 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAITF  = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t st;
    logic   step_req_q;
    logic   stepping;
    logic   valid_q;

    // Decode outputs, taken from the latched ir during DECODE.
    logic [2:0] dec_op;
    logic       dec_hit;
    logic       dec_valid;

    // Next pc wraps inside the inst_mem address space; upper bits stay zero.
    logic [PC_W-1:0] pc_next_low;

    assign state          = st;
    assign imem.inst_addr = pc[ADDR_W+1:2];
    assign pc_next_low    = pc[PC_W-1:0] + PC_W'(4);

    always_comb begin
        dec_op  = 3'b000;
        dec_hit = 1'b0;
        if (ir[31:26] == 6'b000000) begin
            case (ir[5:0])
                6'b100100: begin dec_op = 3'b000; dec_hit = 1'b1; end // AND
                6'b100101: begin dec_op = 3'b001; dec_hit = 1'b1; end // OR
                6'b100110: begin dec_op = 3'b010; dec_hit = 1'b1; end // XOR
                6'b100111: begin dec_op = 3'b011; dec_hit = 1'b1; end // NOR
                6'b100000: begin dec_op = 3'b100; dec_hit = 1'b1; end // ADD
                6'b100010: begin dec_op = 3'b101; dec_hit = 1'b1; end // SUB
                6'b101011: begin dec_op = 3'b110; dec_hit = 1'b1; end // SLTU
                6'b000100: begin dec_op = 3'b111; dec_hit = 1'b1; end // SLLV
                default:   begin dec_op = 3'b000; dec_hit = 1'b0; end
            endcase
        end
        // Writes to r0 are suppressed: the instruction still runs as a NOP.
        dec_valid = dec_hit & (ir[15:11] != 5'd0);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            st         <= S_IDLE;
            pc         <= 32'd0;
            ir         <= 32'd0;
            alu_op     <= 3'b000;
            reg_we     <= 1'b0;
            step_ack   <= 1'b0;
            halted     <= 1'b0;
            retired    <= '0;
            step_req_q <= 1'b0;
            stepping   <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            step_req_q <= step_req;
            // Both pulses are set only on the EXEC->WB edge, so they last
            // exactly the one WB cycle.
            reg_we     <= 1'b0;
            step_ack   <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (run) begin
                        st       <= S_FETCH;
                        stepping <= 1'b0;
                    end else if (step_req && !step_req_q) begin
                        st       <= S_FETCH;
                        stepping <= 1'b1;
                    end
                end
                S_FETCH: st <= S_WAITF;
                S_WAITF: begin
                    ir <= imem.inst_code;
                    st <= S_DECODE;
                end
                S_DECODE: begin
                    if (ir == 32'hFFFF_FFFF) begin
                        st     <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        alu_op  <= dec_op;
                        valid_q <= dec_valid;
                        st      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    reg_we   <= valid_q;
                    step_ack <= stepping;
                    st       <= S_WB;
                end
                S_WB: begin
                    pc       <= {{(32-PC_W){1'b0}}, pc_next_low};
                    retired  <= retired + CNT_W'(1);
                    stepping <= 1'b0;
                    st       <= run ? S_FETCH : S_IDLE;
                end
                S_HALT: st <= S_HALT;
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule
